// File: rtl/axi_perf_pkg.sv
// Shared types and AXI encodings for the AXI performance write sequencer.
package axi_perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_AW    = 2'd1,
        ST_W     = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_perf_wr_seq.sv
// Issues a configurable run of INCR write bursts on an AXI4 manager port,
// collects every B response and reports elapsed cycles and response errors.
module axi_perf_wr_seq
    import axi_perf_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int CYC_WIDTH      = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [AXI_ADDR_WIDTH-1:0]   base_addr,
    input  logic [7:0]                  burst_beats,
    input  logic [AXI_ADDR_WIDTH-1:0]   burst_stride,
    input  logic [2:0]                  burst_awsize,
    input  logic [15:0]                 burst_num,
    output logic                        busy,
    output logic                        done,
    output logic [CYC_WIDTH-1:0]        cycles,
    output logic                        resp_err,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]                  m_axi_bresp
);

    localparam int AW = AXI_ADDR_WIDTH;
    localparam int DW = AXI_DATA_WIDTH;
    localparam int SW = AXI_DATA_WIDTH / 8;

    state_e               state_r;
    logic [AW-1:0]        addr_r;
    logic [AW-1:0]        stride_r;
    logic [7:0]           len_r;
    logic [7:0]           beat_idx_r;
    logic [2:0]           size_r;
    logic [15:0]          num_r;
    logic [15:0]          burst_idx_r;
    logic [15:0]          b_cnt_r;
    logic [DW-1:0]        wdata_r;
    logic                 awvalid_r;
    logic                 wvalid_r;
    logic                 wlast_r;
    logic                 bready_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 resp_err_r;
    logic [CYC_WIDTH-1:0] cycles_r;
    logic                 b_hs_s;
    logic [15:0]          b_cnt_next_s;
    logic                 bid_unused_s;

    // Beat payload tags each word with its burst and beat index for easy tracing.
    function automatic logic [DW-1:0] beat_data(input logic [15:0] burst, input logic [7:0] beat);
        return DW'({burst, beat});
    endfunction

    assign bid_unused_s = ^m_axi_bid;

    // B-channel handshake and response count including any handshake this cycle.
    always_comb begin
        b_hs_s = m_axi_bvalid && bready_r;
        if (b_hs_s) begin
            b_cnt_next_s = b_cnt_r + 16'd1;
        end else begin
            b_cnt_next_s = b_cnt_r;
        end
    end

    // Run sequencer: config latch, AW/W issue, B collection and cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            addr_r      <= {AW{1'b0}};
            stride_r    <= {AW{1'b0}};
            len_r       <= 8'd0;
            beat_idx_r  <= 8'd0;
            size_r      <= 3'd0;
            num_r       <= 16'd0;
            burst_idx_r <= 16'd0;
            b_cnt_r     <= 16'd0;
            wdata_r     <= {DW{1'b0}};
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            wlast_r     <= 1'b0;
            bready_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            resp_err_r  <= 1'b0;
            cycles_r    <= {CYC_WIDTH{1'b0}};
        end else begin
            done_r  <= 1'b0;
            b_cnt_r <= b_cnt_next_s;
            if (b_hs_s && (m_axi_bresp != AXI_RESP_OKAY)) begin
                resp_err_r <= 1'b1;
            end
            if (busy_r && (cycles_r != {CYC_WIDTH{1'b1}})) begin
                cycles_r <= cycles_r + {{(CYC_WIDTH-1){1'b0}}, 1'b1};
            end

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if ((burst_beats == 8'd0) || (burst_num == 16'd0)) begin
                            done_r   <= 1'b1;
                            cycles_r <= {{(CYC_WIDTH-1){1'b0}}, 1'b1};
                        end else begin
                            state_r     <= ST_AW;
                            addr_r      <= base_addr;
                            stride_r    <= burst_stride;
                            len_r       <= burst_beats - 8'd1;
                            size_r      <= burst_awsize;
                            num_r       <= burst_num;
                            burst_idx_r <= 16'd0;
                            b_cnt_r     <= 16'd0;
                            cycles_r    <= {CYC_WIDTH{1'b0}};
                            resp_err_r  <= 1'b0;
                            busy_r      <= 1'b1;
                            bready_r    <= 1'b1;
                            awvalid_r   <= 1'b1;
                        end
                    end
                end
                ST_AW: begin
                    if (m_axi_awready) begin
                        state_r    <= ST_W;
                        awvalid_r  <= 1'b0;
                        wvalid_r   <= 1'b1;
                        beat_idx_r <= 8'd0;
                        wdata_r    <= beat_data(burst_idx_r, 8'd0);
                        wlast_r    <= (len_r == 8'd0);
                    end
                end
                ST_W: begin
                    if (m_axi_wready) begin
                        if (wlast_r) begin
                            wvalid_r    <= 1'b0;
                            wlast_r     <= 1'b0;
                            addr_r      <= addr_r + stride_r;
                            burst_idx_r <= burst_idx_r + 16'd1;
                            if ((burst_idx_r + 16'd1) == num_r) begin
                                state_r <= ST_DRAIN;
                            end else begin
                                state_r   <= ST_AW;
                                awvalid_r <= 1'b1;
                            end
                        end else begin
                            beat_idx_r <= beat_idx_r + 8'd1;
                            wdata_r    <= beat_data(burst_idx_r, beat_idx_r + 8'd1);
                            wlast_r    <= ((beat_idx_r + 8'd1) == len_r);
                        end
                    end
                end
                ST_DRAIN: begin
                    // Responses may all have arrived earlier; then this exits immediately.
                    if (b_cnt_next_s == num_r) begin
                        state_r  <= ST_IDLE;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        bready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    awvalid_r <= 1'b0;
                    wvalid_r  <= 1'b0;
                    wlast_r   <= 1'b0;
                    bready_r  <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign cycles        = cycles_r;
    assign resp_err      = resp_err_r;
    assign m_axi_awvalid = awvalid_r;
    assign m_axi_awaddr  = addr_r;
    assign m_axi_awid    = {AXI_ID_WIDTH{1'b0}};
    assign m_axi_awlen   = len_r;
    assign m_axi_awsize  = size_r;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_wvalid  = wvalid_r;
    assign m_axi_wdata   = wdata_r;
    assign m_axi_wstrb   = {SW{1'b1}};
    assign m_axi_wlast   = wlast_r;
    assign m_axi_bready  = bready_r;

endmodule

// File: tb/tb_axi_perf_wr_seq.sv
// Directed bench for axi_perf_wr_seq with a small responsive AXI slave model.
module tb_axi_perf_wr_seq;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int IW = 4;
    localparam int CW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [AW-1:0]   base_addr = '0;
    logic [7:0]      burst_beats = 8'd0;
    logic [AW-1:0]   burst_stride = '0;
    logic [2:0]      burst_awsize = 3'd0;
    logic [15:0]     burst_num = 16'd0;
    logic            busy, done, resp_err;
    logic [CW-1:0]   cycles;
    logic            awvalid, awready = 1'b1;
    logic [AW-1:0]   awaddr;
    logic [IW-1:0]   awid;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            wvalid, wready = 1'b1;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            bvalid = 1'b0, bready;
    logic [IW-1:0]   bid = '0;
    logic [1:0]      bresp = 2'b00;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave/monitor controls set by the tests.
    bit        stall_en = 1'b0;
    int        err_idx  = -1;
    logic [7:0] exp_len = 8'd0;
    bit        mon_clr  = 1'b0;

    // Monitor state.
    int            aw_cnt, w_cnt, b_cnt_m, wlast_cnt, pend, done_cnt, b_at_done;
    int            data_err, last_err, len_err, stab_err;
    logic [15:0]   m_burst;
    logic [7:0]    m_beat;
    logic [AW-1:0] aw_log [0:63];
    logic [DW-1:0] w_log  [0:2047];
    logic          aw_stall_q, w_stall_q;
    logic [AW-1:0] aw_hold_addr;
    logic [7:0]    aw_hold_len;
    logic [DW-1:0] w_hold_data;
    logic          w_hold_last;

    axi_perf_wr_seq #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .CYC_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .burst_beats(burst_beats), .burst_stride(burst_stride),
        .burst_awsize(burst_awsize), .burst_num(burst_num),
        .busy(busy), .done(done), .cycles(cycles), .resp_err(resp_err),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
        .m_axi_awid(awid), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bid(bid),
        .m_axi_bresp(bresp)
    );

    always #5 clk = ~clk;

    // Slave drive on the falling edge: ready/valid stalls and B responses.
    always @(negedge clk) begin
        awready <= stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
        wready  <= stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
        bvalid  <= (pend > 0) && (stall_en ? ($urandom_range(0, 1) == 1) : 1'b1);
        bresp   <= (b_cnt_m == err_idx) ? 2'b10 : 2'b00;
    end

    // Monitor on the rising edge: logs handshakes, checks data and stability.
    always @(posedge clk) begin
        if (!rst_n || mon_clr) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt_m <= 0; wlast_cnt <= 0; pend <= 0;
            done_cnt <= 0; b_at_done <= -1; data_err <= 0; last_err <= 0;
            len_err <= 0; stab_err <= 0; m_burst <= 16'd0; m_beat <= 8'd0;
            aw_stall_q <= 1'b0; w_stall_q <= 1'b0;
        end else begin
            if (aw_stall_q && (!awvalid || awaddr != aw_hold_addr || awlen != aw_hold_len))
                stab_err <= stab_err + 1;
            if (w_stall_q && (!wvalid || wdata != w_hold_data || wlast != w_hold_last))
                stab_err <= stab_err + 1;
            aw_stall_q <= awvalid && !awready;
            w_stall_q  <= wvalid && !wready;
            aw_hold_addr <= awaddr; aw_hold_len <= awlen;
            w_hold_data  <= wdata;  w_hold_last <= wlast;
            if (awvalid && awready) begin
                if (aw_cnt < 64) aw_log[aw_cnt] <= awaddr;
                if (awlen != exp_len) len_err <= len_err + 1;
                aw_cnt <= aw_cnt + 1;
            end
            if (wvalid && wready) begin
                if (wdata != DW'({m_burst, m_beat})) data_err <= data_err + 1;
                if (wlast != (m_beat == exp_len)) last_err <= last_err + 1;
                if (w_cnt < 2048) w_log[w_cnt] <= wdata;
                w_cnt <= w_cnt + 1;
                if (m_beat == exp_len) begin
                    m_beat <= 8'd0; m_burst <= m_burst + 16'd1;
                end else begin
                    m_beat <= m_beat + 8'd1;
                end
            end
            if (wvalid && wready && wlast) wlast_cnt <= wlast_cnt + 1;
            if (bvalid && bready) b_cnt_m <= b_cnt_m + 1;
            pend <= pend + ((wvalid && wready && wlast) ? 1 : 0) - ((bvalid && bready) ? 1 : 0);
            if (done) begin
                done_cnt <= done_cnt + 1;
                if (done_cnt == 0) b_at_done <= b_cnt_m;
            end
        end
    end

    task automatic start_run(input logic [AW-1:0] base, input logic [7:0] beats,
                             input logic [AW-1:0] stride, input logic [2:0] size,
                             input logic [15:0] num);
        @(negedge clk);
        base_addr = base; burst_beats = beats; burst_stride = stride;
        burst_awsize = size; burst_num = num;
        exp_len = beats - 8'd1;
        start = 1'b1; mon_clr = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; mon_clr = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
        n_tests++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || wlast !== 1'b0 || bready !== 1'b0) begin
            n_fail++; $display("FAIL reset_valids: got aw%0b w%0b l%0b b%0b want 0", awvalid, wvalid, wlast, bready); end
        n_tests++; if (cycles !== 32'd0 || resp_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_counters: got cyc %0d err %0b want 0 0", cycles, resp_err); end
    endtask

    task automatic test_defaults();
        bit to;
        start_run(20'h0, 8'd64, 20'h100, 3'd1, 16'd16);
        n_tests++; if (busy !== 1'b1 || awvalid !== 1'b1) begin
            n_fail++; $display("FAIL def_start: got busy %0b aw %0b want 1 1", busy, awvalid); end
        n_tests++; if (awburst !== 2'b01 || awid !== 4'd0 || wstrb !== 2'b11 || awsize !== 3'd1) begin
            n_fail++; $display("FAIL def_consts: got burst %0b id %0h strb %0b size %0d", awburst, awid, wstrb, awsize); end
        wait_done(3000, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL def_timeout: got timeout want done"); end
        n_tests++; if (cycles !== 32'd1041) begin n_fail++; $display("FAIL def_cycles: got %0d want 1041", cycles); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL def_busy_end: got %0b want 0", busy); end
        @(negedge clk);
        n_tests++; if (done !== 1'b0 || cycles !== 32'd1041) begin
            n_fail++; $display("FAIL def_hold: got done %0b cyc %0d want 0 1041", done, cycles); end
        n_tests++; if (aw_cnt !== 16 || w_cnt !== 1024 || wlast_cnt !== 16 || b_cnt_m !== 16) begin
            n_fail++; $display("FAIL def_counts: got aw %0d w %0d last %0d b %0d want 16 1024 16 16", aw_cnt, w_cnt, wlast_cnt, b_cnt_m); end
        for (int i = 0; i < 16; i++) begin
            n_tests++; if (aw_log[i] !== 20'(i * 256)) begin
                n_fail++; $display("FAIL def_awaddr%0d: got %0h want %0h", i, aw_log[i], i * 256); end
        end
        n_tests++; if (data_err !== 0 || last_err !== 0 || len_err !== 0) begin
            n_fail++; $display("FAIL def_beats: got data %0d last %0d len %0d errors want 0", data_err, last_err, len_err); end
        n_tests++; if (w_log[1023] !== 16'h0F3F) begin n_fail++; $display("FAIL def_lastdata: got %0h want f3f", w_log[1023]); end
        n_tests++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL def_resp_err: got %0b want 0", resp_err); end
    endtask

    task automatic test_wrap();
        bit to;
        start_run(20'hFFF00, 8'd4, 20'h80, 3'd1, 16'd3);
        burst_num = 16'd9; base_addr = 20'h12345;
        wait_done(200, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL wrap_timeout: got timeout want done"); end
        n_tests++; if (cycles !== 32'd16) begin n_fail++; $display("FAIL wrap_cycles: got %0d want 16", cycles); end
        @(negedge clk);
        n_tests++; if (aw_cnt !== 3) begin n_fail++; $display("FAIL wrap_awcnt: got %0d want 3", aw_cnt); end
        n_tests++; if (aw_log[0] !== 20'hFFF00 || aw_log[1] !== 20'hFFF80 || aw_log[2] !== 20'h00000) begin
            n_fail++; $display("FAIL wrap_addr: got %0h %0h %0h want fff00 fff80 0", aw_log[0], aw_log[1], aw_log[2]); end
        n_tests++; if (w_log[11] !== 16'h0203) begin n_fail++; $display("FAIL wrap_wdata: got %0h want 0203", w_log[11]); end
    endtask

    task automatic test_stall();
        bit to;
        stall_en = 1'b1;
        start_run(20'h400, 8'd8, 20'h20, 3'd1, 16'd5);
        wait_done(2000, to);
        stall_en = 1'b0;
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL stall_timeout: got timeout want done"); end
        @(negedge clk);
        n_tests++; if (w_cnt !== 40 || aw_cnt !== 5) begin
            n_fail++; $display("FAIL stall_counts: got w %0d aw %0d want 40 5", w_cnt, aw_cnt); end
        n_tests++; if (stab_err !== 0) begin n_fail++; $display("FAIL stall_stable: got %0d drops want 0", stab_err); end
        n_tests++; if (data_err !== 0 || last_err !== 0) begin
            n_fail++; $display("FAIL stall_data: got data %0d last %0d want 0 0", data_err, last_err); end
        n_tests++; if (b_at_done !== 5 || done_cnt !== 1) begin
            n_fail++; $display("FAIL stall_done_after_b: got b %0d pulses %0d want 5 1", b_at_done, done_cnt); end
        n_tests++; if (aw_log[4] !== 20'h480) begin n_fail++; $display("FAIL stall_addr4: got %0h want 480", aw_log[4]); end
    endtask

    task automatic test_resp_err();
        bit to;
        err_idx = 1;
        start_run(20'h0, 8'd2, 20'h10, 3'd1, 16'd3);
        wait_done(200, to);
        err_idx = -1;
        n_tests++; if (to !== 1'b0 || resp_err !== 1'b1) begin
            n_fail++; $display("FAIL rerr_set: got timeout %0b err %0b want 0 1", to, resp_err); end
        start_run(20'h0, 8'd2, 20'h10, 3'd1, 16'd3);
        @(negedge clk);
        n_tests++; if (resp_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL rerr_clear: got err %0b busy %0b want 0 1", resp_err, busy); end
        wait_done(200, to);
        n_tests++; if (to !== 1'b0 || resp_err !== 1'b0) begin
            n_fail++; $display("FAIL rerr_clean: got timeout %0b err %0b want 0 0", to, resp_err); end
    endtask

    task automatic test_noop();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) start_run(20'h0, 8'd4, 20'h10, 3'd1, 16'd0);
            else        start_run(20'h0, 8'd0, 20'h10, 3'd1, 16'd4);
            @(negedge clk);
            n_tests++; if (done !== 1'b1 || cycles !== 32'd1 || busy !== 1'b0) begin
                n_fail++; $display("FAIL noop%0d_done: got done %0b cyc %0d busy %0b want 1 1 0", k, done, cycles, busy); end
            @(negedge clk);
            @(negedge clk);
            n_tests++; if (done !== 1'b0 || aw_cnt !== 0 || awvalid !== 1'b0) begin
                n_fail++; $display("FAIL noop%0d_quiet: got done %0b aw %0d awv %0b want 0 0 0", k, done, aw_cnt, awvalid); end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        start_run(20'h0, 8'd16, 20'h40, 3'd1, 16'd4);
        repeat (8) @(negedge clk);
        n_tests++; if (wvalid !== 1'b1) begin n_fail++; $display("FAIL rmid_inburst: got wvalid %0b want 1", wvalid); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL rmid_async: got aw %0b w %0b busy %0b done %0b want 0", awvalid, wvalid, busy, done); end
        @(negedge clk);
        rst_n = 1'b1;
        start_run(20'h100, 8'd4, 20'h10, 3'd1, 16'd2);
        wait_done(200, to);
        n_tests++; if (to !== 1'b0 || cycles !== 32'd11) begin
            n_fail++; $display("FAIL rmid_rerun: got timeout %0b cyc %0d want 0 11", to, cycles); end
        @(negedge clk);
        n_tests++; if (aw_cnt !== 2 || aw_log[0] !== 20'h100 || data_err !== 0 || w_cnt !== 8) begin
            n_fail++; $display("FAIL rmid_clean: got aw %0d a0 %0h derr %0d w %0d want 2 100 0 8", aw_cnt, aw_log[0], data_err, w_cnt); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_defaults();
        test_wrap();
        test_stall();
        test_resp_err();
        test_noop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
